// File: rtl/drive_cmd_arbiter.sv
// Drive command arbiter: picks the camera or IR drive code by mode, ramps the
// shared PWM duty toward the commanded speed, and inserts brake plus dead time
// before any motor direction change. A watchdog forces STOP on a silent source.
module drive_cmd_arbiter #(
  parameter int unsigned RAMP_DIV  = 4,
  parameter int unsigned RAMP_STEP = 16,
  parameter int unsigned DEADTIME  = 8,
  parameter int unsigned TIMEOUT   = 100,
  parameter int unsigned DUTY_SLOW = 64,
  parameter int unsigned DUTY_MED  = 128,
  parameter int unsigned DUTY_FAST = 255,
  parameter int unsigned DUTY_TURN = 96
) (
  input  logic       clk_50,
  input  logic       reset_n,
  input  logic [1:0] mode,
  input  logic       mode_change,
  input  logic [2:0] cam_cmd,
  input  logic       cam_valid,
  input  logic [2:0] ir_cmd,
  input  logic       ir_valid,
  output logic [7:0] duty,
  output logic       left_dir,
  output logic       right_dir,
  output logic       busy,
  output logic       timed_out
);

  localparam int unsigned DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned DT_W  = (DEADTIME > 0) ? $clog2(DEADTIME + 1) : 1;

  localparam logic [2:0] CMD_STOP  = 3'b000;
  localparam logic [2:0] CMD_LEFT  = 3'b001;
  localparam logic [2:0] CMD_RIGHT = 3'b010;
  localparam logic [2:0] CMD_SLOW  = 3'b011;
  localparam logic [2:0] CMD_MED   = 3'b100;
  localparam logic [2:0] CMD_FAST  = 3'b101;

  localparam logic [1:0] MODE_CAM = 2'b01;
  localparam logic [1:0] MODE_IR  = 2'b10;

  typedef enum logic [1:0] {ST_RUN, ST_BRAKE, ST_DEAD} state_t;

  state_t            r_state, w_state_nxt;
  logic [2:0]        r_cmd_q;
  logic [WD_W-1:0]   r_wd_cnt;
  logic              r_timed_out;
  logic [DIV_W-1:0]  r_div_cnt;
  logic [DT_W-1:0]   r_dead_cnt, w_dead_nxt;
  logic [7:0]        r_duty, w_duty_nxt;
  logic              r_left_dir, r_right_dir, w_left_nxt, w_right_nxt;
  logic              r_pend_l, r_pend_r, w_pend_l_nxt, w_pend_r_nxt;
  logic              r_busy;

  logic              w_idle, w_sel_valid, w_tick, w_dir_diff;
  logic [2:0]        w_sel_cmd;
  logic              w_tgt_stop, w_tgt_l, w_tgt_r;
  logic [7:0]        w_tgt_duty;
  logic [8:0]        w_up, w_dn;
  logic [7:0]        w_up_sat, w_dn_sat, w_ramp;

  assign w_idle      = (mode != MODE_CAM) && (mode != MODE_IR);
  assign w_sel_valid = ((mode == MODE_CAM) && cam_valid) || ((mode == MODE_IR) && ir_valid);
  assign w_sel_cmd   = (mode == MODE_CAM) ? cam_cmd : ir_cmd;
  assign w_tick      = (r_div_cnt == DIV_W'(RAMP_DIV - 1));

  // Command latch and watchdog, in priority order: mode change, idle, expiry, valid.
  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      r_cmd_q     <= CMD_STOP;
      r_wd_cnt    <= '0;
      r_timed_out <= 1'b0;
    end else if (mode_change || w_idle) begin
      r_cmd_q     <= CMD_STOP;
      r_wd_cnt    <= '0;
      r_timed_out <= 1'b0;
    end else if (r_wd_cnt == WD_W'(TIMEOUT - 1)) begin
      r_cmd_q     <= CMD_STOP;
      r_wd_cnt    <= WD_W'(TIMEOUT);
      r_timed_out <= 1'b1;
    end else if (w_sel_valid) begin
      r_cmd_q     <= w_sel_cmd;
      r_wd_cnt    <= '0;
      r_timed_out <= 1'b0;
    end else if (r_wd_cnt != WD_W'(TIMEOUT)) begin
      r_wd_cnt    <= r_wd_cnt + WD_W'(1);
    end
  end

  // Free-running ramp divider.
  always_ff @(posedge clk_50) begin
    if (!reset_n)    r_div_cnt <= '0;
    else if (w_tick) r_div_cnt <= '0;
    else             r_div_cnt <= r_div_cnt + DIV_W'(1);
  end

  // Decode the latched command into target duty and direction pattern.
  always_comb begin
    w_tgt_stop = 1'b0;
    w_tgt_duty = 8'd0;
    w_tgt_l    = r_left_dir;
    w_tgt_r    = r_right_dir;
    case (r_cmd_q)
      CMD_LEFT:  begin w_tgt_duty = 8'(DUTY_TURN); w_tgt_l = 1'b0; w_tgt_r = 1'b1; end
      CMD_RIGHT: begin w_tgt_duty = 8'(DUTY_TURN); w_tgt_l = 1'b1; w_tgt_r = 1'b0; end
      CMD_SLOW:  begin w_tgt_duty = 8'(DUTY_SLOW); w_tgt_l = 1'b1; w_tgt_r = 1'b1; end
      CMD_MED:   begin w_tgt_duty = 8'(DUTY_MED);  w_tgt_l = 1'b1; w_tgt_r = 1'b1; end
      CMD_FAST:  begin w_tgt_duty = 8'(DUTY_FAST); w_tgt_l = 1'b1; w_tgt_r = 1'b1; end
      default:   w_tgt_stop = 1'b1;
    endcase
  end

  // 9-bit ramp arithmetic saturated to 0..255, clamped at the target.
  assign w_up     = {1'b0, r_duty} + 9'(RAMP_STEP);
  assign w_dn     = {1'b0, r_duty} - 9'(RAMP_STEP);
  assign w_up_sat = w_up[8] ? 8'hFF : w_up[7:0];
  assign w_dn_sat = ({1'b0, r_duty} < 9'(RAMP_STEP)) ? 8'h00 : w_dn[7:0];
  assign w_ramp   = (r_duty < w_tgt_duty) ? ((w_up_sat > w_tgt_duty) ? w_tgt_duty : w_up_sat) :
                    (r_duty > w_tgt_duty) ? ((w_dn_sat < w_tgt_duty) ? w_tgt_duty : w_dn_sat) :
                    r_duty;

  // STOP carries no direction of its own, so it never triggers a reversal.
  assign w_dir_diff   = !w_tgt_stop && ({w_tgt_l, w_tgt_r} != {r_left_dir, r_right_dir});
  assign w_pend_l_nxt = w_tgt_stop ? r_pend_l : w_tgt_l;
  assign w_pend_r_nxt = w_tgt_stop ? r_pend_r : w_tgt_r;

  // Next-state and datapath for the RUN / BRAKE / DEAD sequencer.
  always_comb begin
    w_state_nxt = r_state;
    w_duty_nxt  = r_duty;
    w_left_nxt  = r_left_dir;
    w_right_nxt = r_right_dir;
    w_dead_nxt  = r_dead_cnt;
    case (r_state)
      ST_RUN: begin
        if (w_dir_diff) begin
          if (r_duty == 8'd0) begin
            w_state_nxt = ST_DEAD;
            w_dead_nxt  = DT_W'(DEADTIME);
          end else begin
            w_state_nxt = ST_BRAKE;
          end
        end else if (w_tick) begin
          w_duty_nxt = w_ramp;
        end
      end
      ST_BRAKE: begin
        if (!w_tgt_stop && !w_dir_diff) begin
          w_state_nxt = ST_RUN;
        end else if (r_duty == 8'd0) begin
          w_state_nxt = ST_DEAD;
          w_dead_nxt  = DT_W'(DEADTIME);
        end else if (w_tick) begin
          w_duty_nxt = w_dn_sat;
        end
      end
      ST_DEAD: begin
        w_duty_nxt = 8'd0;
        if (r_dead_cnt <= DT_W'(1)) begin
          w_state_nxt = ST_RUN;
          w_dead_nxt  = '0;
          w_left_nxt  = w_pend_l_nxt;
          w_right_nxt = w_pend_r_nxt;
        end else begin
          w_dead_nxt  = r_dead_cnt - DT_W'(1);
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      r_state     <= ST_RUN;
      r_duty      <= 8'd0;
      r_left_dir  <= 1'b1;
      r_right_dir <= 1'b1;
      r_pend_l    <= 1'b1;
      r_pend_r    <= 1'b1;
      r_dead_cnt  <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_duty      <= w_duty_nxt;
      r_left_dir  <= w_left_nxt;
      r_right_dir <= w_right_nxt;
      r_pend_l    <= w_pend_l_nxt;
      r_pend_r    <= w_pend_r_nxt;
      r_dead_cnt  <= w_dead_nxt;
      r_busy      <= (w_state_nxt != ST_RUN);
    end
  end

  assign duty      = r_duty;
  assign left_dir  = r_left_dir;
  assign right_dir = r_right_dir;
  assign busy      = r_busy;
  assign timed_out = r_timed_out;

endmodule

// File: doc/drive_cmd_arbiter.md
# drive_cmd_arbiter

Sits between the mode FSM and the motor PWM generators. Selects the drive command from the camera path or the IR remote path according to the current mode, ramps the duty cycle toward the commanded speed, and enforces a brake-plus-dead-time sequence before any change of motor direction. A watchdog forces STOP if the selected source goes silent.

## Interface

Parameters:
- RAMP_DIV, 4: clock cycles per ramp tick.
- RAMP_STEP, 16: maximum duty change per tick.
- DEADTIME, 8: cycles at zero duty before a direction change.
- TIMEOUT, 100: cycles without a valid command from the selected source before a forced STOP.
- DUTY_SLOW / DUTY_MED / DUTY_FAST / DUTY_TURN, 64 / 128 / 255 / 96: target duties.

Ports:
- clk_50  in  1  system clock; the only clock.
- reset_n  in  1  synchronous, active-low reset.
- mode  in  2  00 IDLE, 01 CAM, 10 IR, 11 treated as IDLE.
- mode_change  in  1  one-cycle pulse from the mode FSM on any mode or sub-state change.
- cam_cmd  in  3  drive code from the camera path.
- cam_valid  in  1  cam_cmd qualifier.
- ir_cmd  in  3  drive code from the IR decoder.
- ir_valid  in  1  ir_cmd qualifier.
- duty  out  8  PWM duty, common to both motors.
- left_dir, right_dir  out  1 each  1 = forward.
- busy  out  1  high when state is BRAKE or DEAD.
- timed_out  out  1  watchdog has fired.

## Operation

- **Drive codes:** STOP 000, LEFT 001, RIGHT 010, SLOW 011, MEDIUM 100, FAST 101. Codes 110 and 111 are treated as STOP.
- **Targets:**
  - STOP: target duty 0, direction unchanged.
  - LEFT: dirs (L,R) = (0,1), DUTY_TURN.
  - RIGHT: dirs (1,0), DUTY_TURN.
  - SLOW / MEDIUM / FAST: dirs (1,1), DUTY_SLOW / DUTY_MED / DUTY_FAST.
- **Source select:** CAM mode takes cam_*, IR mode takes ir_*, IDLE mode forces the latched command to STOP. Valids from the non-selected source are ignored.
- **Command latch (cmd_q):** loads the selected code on a selected valid.
- **Priority, highest first:** reset_n low, then mode_change (cmd_q = STOP, watchdog cleared), then IDLE, then watchdog expiry, then valid.
- **Watchdog:**
  - Counts cycles since the last selected valid and saturates at TIMEOUT.
  - At TIMEOUT: cmd_q = STOP and timed_out = 1.
  - A selected valid clears both the counter and timed_out.
  - The watchdog is held clear in IDLE.
- **Ramp divider:** free-running 0..RAMP_DIV-1; tick when the count equals RAMP_DIV-1.
- **FSM states:**
  - RUN:
    - If the target direction pattern differs from the current one and the target is not STOP:
      - duty == 0: go to DEAD and load the dead-time counter with DEADTIME.
      - otherwise: go to BRAKE.
    - Otherwise, on each tick, move duty toward the target by at most RAMP_STEP, clamping exactly at the target with no overshoot.
  - BRAKE:
    - On each tick, duty steps down by RAMP_STEP, floored at 0.
    - When duty == 0, go to DEAD and load the counter with DEADTIME.
    - If the target pattern returns to the current direction, go back to RUN on the next cycle.
  - DEAD:
    - duty held at 0; the counter decrements every cycle.
    - When the counter reaches 0: load left_dir/right_dir from the target pattern and go to RUN.
    - DEAD always runs to completion, even if the command changes.
- **Arithmetic:** ramp arithmetic is done 9 bits wide and saturates to 0..255.

## Timing

- **Reset values:** duty = 0, left_dir = right_dir = 1, busy = 0, timed_out = 0, state RUN, cmd_q = STOP, all counters 0.
- **Registered outputs:** all outputs are registered. A valid sampled at edge N updates cmd_q at N. The first duty change occurs on the first ramp tick after N+1.
- **Direction changes:** the direction outputs change only on the DEAD→RUN edge, and duty is always 0 on that edge.
- **Minimum reversal time:** ceil(duty/RAMP_STEP) ticks of braking, plus DEADTIME cycles, plus 1.
- **busy:** asserted from the cycle the FSM enters BRAKE or DEAD through the DEAD→RUN edge.
- **Reset mid-ramp or mid-DEAD:** all state returns to reset values on the next edge.
- **mode_change during BRAKE or DEAD:** the sequence continues, now targeting STOP. The FSM ends in RUN at duty 0 with the new direction pattern already applied.

## Test plan

Default parameters throughout.

1. **Ramp up:** reset, mode = IR, ir_cmd = FAST with one ir_valid pulse. Required: duty rises 16, 32, … on every 4th cycle and reaches 255 at tick 16. Dirs stay (1,1) and busy = 0.
2. **Reversal:** from duty 128 forward, ir_cmd = LEFT. Required:
   - busy rises; duty falls 112, 96, … to 0 over 8 ticks.
   - 8 cycles at 0 follow, then dirs become (0,1).
   - duty then ramps to 96 and busy falls on the DEAD→RUN edge.
3. **Watchdog:** CAM mode, one cam_valid with SLOW, then no further valids. Required: at cycle 100, timed_out = 1 and duty ramps to 0. A new cam_valid clears timed_out.
4. **Source isolation:** IR mode, cam_valid pulses carrying FAST. Required: duty stays 0. Switching mode to IDLE while at MEDIUM ramps duty to 0.
5. **Simultaneous events:** mode_change and ir_valid(FAST) in the same cycle. Required: cmd_q = STOP and duty stays 0.
6. **Reset mid-operation:** reset_n low for 1 cycle during DEAD. Required: next cycle duty = 0, dirs = (1,1), busy = 0, state RUN.
